// File: rtl/operand_stage.sv
// operand_stage: sits between the instruction fetcher and the execute unit.
// It captures a decoded instruction, fetches its memory operand when the
// addressing mode needs one, and issues {opcode, operand, ea} over a
// valid/ready handshake. instruction_done pulses once execution retires.
//
// Optional feature macro: OPSTAGE_STORE_SKIP_EN
//   Defined   : store opcodes (opcode[7:5]==3'b100 in the MEM class) skip the
//               operand read and issue with operand_out = 0.
//   Undefined : stores perform the same dummy read as every other MEM op.
//
// All outputs are registered. Reset is synchronous and active-high.

module operand_stage #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  phi1,
  input  logic                  reset,
  input  logic                  instruction_ready,
  input  logic [REG_WIDTH-1:0]  instruction_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [REG_WIDTH-1:0]  imm_in,
  input  logic [REG_WIDTH-1:0]  mem_data_in,
  input  logic                  exec_ready,
  input  logic                  exec_done,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  exec_valid,
  output logic [REG_WIDTH-1:0]  opcode_out,
  output logic [REG_WIDTH-1:0]  operand_out,
  output logic [ADDR_WIDTH-1:0] ea_out,
  output logic                  instruction_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MEM_RD    = 3'd1,
    MEM_LAT   = 3'd2,
    ISSUE     = 3'd3,
    WAIT_EXEC = 3'd4,
    DONE      = 3'd5,
    RELEASE   = 3'd6
  } state_t;

  // Operand source for the instruction currently offered by the fetcher.
  typedef enum logic [1:0] {
    CLS_IMM   = 2'd0,  // operand is the immediate / branch offset
    CLS_NONE  = 2'd1,  // implied / accumulator: operand is zero
    CLS_MEM   = 2'd2,  // operand read from memory at addr_in
    CLS_STORE = 2'd3   // store with the read skipped: operand is zero
  } op_class_e;

  state_t                  state_q, state_d;
  logic [REG_WIDTH-1:0]    opcode_q, opcode_d;
  logic [REG_WIDTH-1:0]    operand_q, operand_d;
  logic [ADDR_WIDTH-1:0]   ea_q, ea_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    exec_valid_q, exec_valid_d;
  logic                    done_q, done_d;

  logic [2:0]              mode;
  logic [1:0]              cc;
  op_class_e               op_class;

  // Classify the incoming opcode by addressing mode (bits 4:2) and group (bits 1:0).
  always_comb begin
    mode     = instruction_in[4:2];
    cc       = instruction_in[1:0];
    op_class = CLS_MEM;
    if ((mode == 3'b000 && cc != 2'b01) ||
        (mode == 3'b010 && cc == 2'b01) ||
        (instruction_in[4:0] == 5'b10000)) begin
      op_class = CLS_IMM;
    end else if ((mode == 3'b010 && cc != 2'b01) ||
                 (mode == 3'b110 && cc == 2'b00)) begin
      op_class = CLS_NONE;
    end
`ifdef OPSTAGE_STORE_SKIP_EN
    else if (instruction_in[7:5] == 3'b100) begin
      op_class = CLS_STORE;
    end
`endif
  end

  // Next-state, latched-bundle and registered-output computation.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    ea_d      = ea_q;

    case (state_q)
      IDLE: begin
        if (instruction_ready) begin
          opcode_d  = instruction_in;
          ea_d      = addr_in;
          operand_d = '0;
          case (op_class)
            CLS_IMM: begin
              operand_d = imm_in;
              state_d   = ISSUE;
            end
            CLS_MEM:  state_d = MEM_RD;
            default:  state_d = ISSUE;  // CLS_NONE, CLS_STORE
          endcase
        end
      end
      MEM_RD:  state_d = MEM_LAT;
      MEM_LAT: begin
        // Memory answers one cycle after the strobe, i.e. during this state.
        operand_d = mem_data_in;
        state_d   = ISSUE;
      end
      ISSUE: begin
        if (exec_ready) begin
          state_d = exec_done ? DONE : WAIT_EXEC;
        end
      end
      WAIT_EXEC: begin
        if (exec_done) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = RELEASE;
      RELEASE: begin
        // The fetcher must drop ready before another capture can happen.
        if (!instruction_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    mem_rd_d     = (state_d == MEM_RD);
    mem_addr_d   = mem_rd_d ? ea_d : '0;
    exec_valid_d = (state_d == ISSUE);
    done_d       = (state_d == DONE);
  end

  // State and output registers; reset clears everything and aborts the instruction.
  always_ff @(posedge phi1) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      opcode_q     <= '0;
      operand_q    <= '0;
      ea_q         <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      exec_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      operand_q    <= operand_d;
      ea_q         <= ea_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      exec_valid_q <= exec_valid_d;
      done_q       <= done_d;
    end
  end

  assign mem_rd           = mem_rd_q;
  assign mem_addr         = mem_addr_q;
  assign exec_valid       = exec_valid_q;
  assign opcode_out       = opcode_q;
  assign operand_out      = operand_q;
  assign ea_out           = ea_q;
  assign instruction_done = done_q;

endmodule

// File: tb/tb_operand_stage.sv
// Testbench for operand_stage. Plays fetcher, memory and execute unit, and
// predicts every instruction's behaviour from the operand-class rules.
// Honours OPSTAGE_STORE_SKIP_EN the same way the design does.

module tb_operand_stage;

  localparam int K_IMM  = 0;
  localparam int K_NONE = 1;
  localparam int K_MEM  = 2;
  localparam int K_SKIP = 3;

  logic        phi1;
  logic        reset;
  logic        instruction_ready;
  logic [7:0]  instruction_in;
  logic [15:0] addr_in;
  logic [7:0]  imm_in;
  logic [7:0]  mem_data_in;
  logic        exec_ready;
  logic        exec_done;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        exec_valid;
  logic [7:0]  opcode_out;
  logic [7:0]  operand_out;
  logic [15:0] ea_out;
  logic        instruction_done;

  int n_cmp = 0;
  int n_bad = 0;

  operand_stage #(.REG_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .phi1              (phi1),
    .reset             (reset),
    .instruction_ready (instruction_ready),
    .instruction_in    (instruction_in),
    .addr_in           (addr_in),
    .imm_in            (imm_in),
    .mem_data_in       (mem_data_in),
    .exec_ready        (exec_ready),
    .exec_done         (exec_done),
    .mem_rd            (mem_rd),
    .mem_addr          (mem_addr),
    .exec_valid        (exec_valid),
    .opcode_out        (opcode_out),
    .operand_out       (operand_out),
    .ea_out            (ea_out),
    .instruction_done  (instruction_done)
  );

  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge phi1);
    @(negedge phi1);
  endtask

  // Operand class from the opcode's low five bits, using plain arithmetic.
  function automatic int classify(input logic [7:0] op);
    int low5, mode, cc;
    low5 = int'(op) % 32;
    mode = low5 / 4;
    cc   = low5 % 4;
    if ((mode == 0 && cc != 1) || (mode == 2 && cc == 1) || low5 == 16) return K_IMM;
    if ((mode == 2 && cc != 1) || (mode == 6 && cc == 0)) return K_NONE;
`ifdef OPSTAGE_STORE_SKIP_EN
    if (int'(op) / 32 == 4) return K_SKIP;
`endif
    return K_MEM;
  endfunction

  function automatic logic [63:0] all_outputs();
    return {13'd0, mem_rd, mem_addr, exec_valid, opcode_out, operand_out, ea_out, instruction_done};
  endfunction

  // Drive one complete instruction through the block and check it end to end.
  task automatic run_instr(input logic [7:0] opc, input logic [15:0] addr,
                           input logic [7:0] imm, input logic [7:0] mval,
                           input int hold, input bit together, input int wait_cyc,
                           input int post_hold, input bit drop_early, input bit noise);
    int         kind, exp_lat, lat, pulses;
    bit         got, rd_seen;
    logic [7:0] exp_op;
    kind    = classify(opc);
    exp_lat = (kind == K_MEM) ? 3 : 1;
    exp_op  = (kind == K_IMM) ? imm : (kind == K_MEM) ? mval : 8'h00;

    instruction_ready = 1'b1;
    instruction_in    = opc;
    addr_in           = addr;
    imm_in            = imm;
    lat = 0; pulses = 0; got = 1'b0; rd_seen = 1'b0;
    while (!got && lat < 8) begin
      tick();
      lat++;
      // Memory returns the byte one cycle after it saw the strobe, junk otherwise.
      mem_data_in = rd_seen ? mval : 8'($urandom);
      rd_seen     = mem_rd;
      if (mem_rd) begin
        pulses++;
        check("mem_addr", 64'(mem_addr), 64'(addr));
      end else begin
        check("mem_addr_idle", 64'(mem_addr), 64'd0);
      end
      check("done_early", 64'(instruction_done), 64'd0);
      if (exec_valid) begin
        got = 1'b1;
      end else if (noise) begin
        exec_done  = 1'($urandom);
        exec_ready = 1'($urandom);
      end
      if (drop_early) begin
        instruction_ready = 1'b0;
        instruction_in    = 8'($urandom);
        addr_in           = 16'($urandom);
        imm_in            = 8'($urandom);
      end
    end
    exec_ready = 1'b0;
    exec_done  = 1'b0;

    check("issue_latency", 64'(lat), 64'(exp_lat));
    check("mem_rd_pulses", 64'(pulses), (kind == K_MEM) ? 64'd1 : 64'd0);
    check("opcode_out", 64'(opcode_out), 64'(opc));
    check("operand_out", 64'(operand_out), 64'(exp_op));
    check("ea_out", 64'(ea_out), 64'(addr));

    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 64'(exec_valid), 64'd1);
      check("hold_bundle", {32'd0, opcode_out, operand_out, ea_out}, {32'd0, opc, exp_op, addr});
      check("hold_mem_rd", 64'(mem_rd), 64'd0);
    end

    exec_ready = 1'b1;
    exec_done  = together;
    tick();
    exec_ready = 1'b0;
    exec_done  = 1'b0;
    if (!together) begin
      check("wait_valid", 64'(exec_valid), 64'd0);
      check("wait_done", 64'(instruction_done), 64'd0);
      for (int i = 0; i < wait_cyc; i++) begin
        tick();
        check("wait_valid", 64'(exec_valid), 64'd0);
        check("wait_done", 64'(instruction_done), 64'd0);
      end
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
    end
    check("done_pulse", 64'(instruction_done), 64'd1);
    check("done_valid", 64'(exec_valid), 64'd0);

    // After retirement: no second pulse and no recapture while ready stays high.
    for (int i = 0; i <= post_hold; i++) begin
      if (noise) exec_done = 1'($urandom);
      if (instruction_ready) begin
        instruction_in = 8'($urandom);
        addr_in        = 16'($urandom);
      end
      tick();
      check("done_once", 64'(instruction_done), 64'd0);
      check("no_recapture", 64'(exec_valid), 64'd0);
      check("no_recapture_rd", 64'(mem_rd), 64'd0);
      check("opcode_kept", 64'(opcode_out), 64'(opc));
    end
    instruction_ready = 1'b0;
    exec_done         = 1'b0;
    tick();
    check("release_idle", 64'(exec_valid | instruction_done | mem_rd), 64'd0);
  endtask

  initial begin
    reset             = 1'b1;
    instruction_ready = 1'b1;  // reset must win over a waiting instruction
    instruction_in    = 8'hA9;
    addr_in           = 16'h1234;
    imm_in            = 8'h42;
    mem_data_in       = 8'h00;
    exec_ready        = 1'b1;
    exec_done         = 1'b1;
    repeat (3) tick();
    check("reset_outputs", all_outputs(), 64'd0);
    instruction_ready = 1'b0;
    exec_ready        = 1'b0;
    exec_done         = 1'b0;
    reset             = 1'b0;
    tick();
    check("idle_outputs", all_outputs(), 64'd0);

    // LDA #$42
    run_instr(8'hA9, 16'h0000, 8'h42, 8'h00, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    // LDA $0010, memory returns $5A
    run_instr(8'hAD, 16'h0010, 8'h00, 8'h5A, 1, 1'b0, 1, 0, 1'b0, 1'b0);
    // STA $0200
    run_instr(8'h8D, 16'h0200, 8'h00, 8'h77, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    // CLC with exec_ready held low 3 cycles, then ready and done together
    run_instr(8'h18, 16'h0000, 8'h00, 8'h00, 3, 1'b1, 0, 0, 1'b0, 1'b0);
    // BEQ with ready held high for a while after done
    run_instr(8'hF0, 16'h0000, 8'hFE, 8'h00, 0, 1'b0, 0, 3, 1'b0, 1'b0);
    run_instr(8'hA2, 16'h0000, 8'h11, 8'h00, 0, 1'b1, 0, 0, 1'b0, 1'b0);

    // Reset during MEM_LAT of an LDA abs aborts it.
    instruction_ready = 1'b1;
    instruction_in    = 8'hAD;
    addr_in           = 16'h0010;
    tick();
    check("abort_mem_rd", 64'(mem_rd), 64'd1);
    tick();
    mem_data_in       = 8'h5A;
    reset             = 1'b1;
    instruction_ready = 1'b0;
    tick();
    check("abort_outputs", all_outputs(), 64'd0);
    reset     = 1'b0;
    exec_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exec_done = 1'b0;
      check("abort_no_done", 64'(instruction_done | exec_valid | mem_rd), 64'd0);
    end
    run_instr(8'hA9, 16'h0000, 8'h33, 8'h00, 0, 1'b0, 0, 0, 1'b0, 1'b0);

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      run_instr(8'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
